// File: rtl/dsp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mul_arbiter
// Description : Round-robin arbiter sharing one registered signed multiplier
//               (A/B input regs, P output reg) between NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 25,
    parameter int BW   = 18,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_a,
    input  logic [NREQ*BW-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [AW+BW-1:0]     rsp_p,
    output logic                 busy
);

    logic signed [AW-1:0]    r_a;
    logic signed [BW-1:0]    r_b;
    logic [IDW-1:0]          r_id1;
    logic                    r_v1;
    logic signed [AW+BW-1:0] r_p;
    logic [IDW-1:0]          r_id2;
    logic                    r_v2;
    logic [IDW-1:0]          r_ptr;

    logic                    w_stall;
    logic                    w_found;
    logic                    w_accept;
    logic [IDW-1:0]          w_gnt;
    logic [IDW-1:0]          w_ptr_nxt;
    logic [AW-1:0]           w_sel_a;
    logic [BW-1:0]           w_sel_b;
    logic signed [AW+BW-1:0] w_prod;

    assign w_stall = r_v2 & ~rsp_ready;

    // Two passes: indices at/after the pointer first, then the wrapped-around ones.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
                w_found = 1'b1;
                w_gnt   = IDW'(i);
                w_sel_a = req_a[i*AW +: AW];
                w_sel_b = req_b[i*BW +: BW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
                w_found = 1'b1;
                w_gnt   = IDW'(i);
                w_sel_a = req_a[i*AW +: AW];
                w_sel_b = req_b[i*BW +: BW];
            end
        end
    end

    assign w_accept  = w_found & ~w_stall & ~rst;
    assign w_ptr_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    assign w_prod = (AW+BW)'(r_a) * (AW+BW)'(r_b);

    // Every stage shares the single ~stall enable so the DSP absorbs A/B/P.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_id1 <= '0;
            r_v1  <= 1'b0;
            r_ptr <= '0;
        end else if (!w_stall) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_id1 <= w_gnt;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p   <= '0;
            r_id2 <= '0;
            r_v2  <= 1'b0;
        end else if (!w_stall) begin
            r_p   <= w_prod;
            r_id2 <= r_id1;
            r_v2  <= r_v1;
        end
    end

    assign rsp_valid = r_v2;
    assign rsp_id    = r_id2;
    assign rsp_p     = r_p;
    assign busy      = r_v1 | r_v2;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_mul_arbiter
// Description : Self-checking bench: vector table, directed sequences and
//               random traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_mul_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [99:0] req_a;
    logic [71:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [42:0] rsp_p;
    logic        busy;

    logic signed [24:0] opa [4];
    logic signed [17:0] opb [4];

    dsp_mul_arbiter #(.NREQ(4), .AW(25), .BW(18)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*25 +: 25] = opa[i];
            req_b[i*18 +: 18] = opb[i];
        end
    end

    int     n_vec = 0;
    int     n_bad = 0;
    // Reference model: spec-level pipeline of (valid, id, product) plus pointer
    int     m_ptr;
    bit     m_v1, m_v2;
    int     m_id1, m_id2;
    longint m_p1, m_p2;
    bit     keep_valid;
    int     last_grant;
    bit     got_rsp;
    int     got_id;
    longint got_p;
    int     n_acc = 0;
    int     n_rsp = 0;

    typedef struct {
        int     id;
        longint a;
        longint b;
        longint p;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_v1 = 0; m_v2 = 0;
        m_id1 = 0; m_id2 = 0; m_p1 = 0; m_p2 = 0;
    endtask

    // One clock: check at negedge, advance the model at posedge, release on accept.
    task automatic cycle();
        bit     stall, found, acc;
        int     g;
        longint p_new;
        @(negedge clk);
        stall = m_v2 && !rsp_ready;
        found = 0;
        g     = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && req_valid[(m_ptr + k) % 4]) begin
                found = 1;
                g     = (m_ptr + k) % 4;
            end
        end
        acc = found && !stall && !rst;
        chk("req_ready", longint'(req_ready), acc ? (longint'(1) << g) : 0);
        chk("rsp_valid", longint'(rsp_valid), longint'(m_v2));
        chk("busy", longint'(busy), longint'(m_v1 | m_v2));
        if (m_v2) begin
            chk("rsp_id", longint'(rsp_id), longint'(m_id2));
            chk("rsp_p", longint'($signed(rsp_p)), m_p2);
        end
        got_rsp = rsp_valid && rsp_ready;
        got_id  = int'(rsp_id);
        got_p   = longint'($signed(rsp_p));
        if (got_rsp) n_rsp++;
        if (acc) n_acc++;
        last_grant = acc ? g : -1;
        p_new = longint'(opa[g]) * longint'(opb[g]);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!stall) begin
            m_v2 = m_v1; m_id2 = m_id1; m_p2 = m_p1;
            m_v1 = acc;
            if (acc) begin
                m_id1 = g;
                m_p1  = p_new;
                m_ptr = (g + 1) % 4;
            end
        end
        #1;
        if (acc && !keep_valid) req_valid[g] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, rsp0;
        bit done;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 25'(i + 1);
            opb[i] = 18'(i + 7);
        end
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1; keep_valid = 1'b1;
        model_reset();
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0; req_valid = 4'b0000;
        chk("reset_rsp_valid", longint'(rsp_valid), 0);
        chk("reset_rsp_id", longint'(rsp_id), 0);
        chk("reset_rsp_p", longint'(rsp_p), 0);
        chk("reset_busy", longint'(busy), 0);

        // Fairness: all four held for eight accepts
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("fair_grant", last_grant, i % 4);
        end
        req_valid = 4'b0000; keep_valid = 1'b0;
        repeat (3) cycle();

        // Single-op vector table, including operand extremes
        tbl[0] = '{2, 3, -5, -15};
        tbl[1] = '{0, -(64'sd1 <<< 24), -(64'sd1 <<< 17), 64'sd1 <<< 41};
        tbl[2] = '{3, (64'sd1 <<< 24) - 1, -(64'sd1 <<< 17), -((64'sd1 <<< 41) - (64'sd1 <<< 17))};
        tbl[3] = '{1, -1, -1, 1};
        tbl[4] = '{1, 0, -131072, 0};
        tbl[5] = '{2, 16777215, 131071, 64'sd2199006347265};
        for (int i = 0; i < 6; i++) begin
            opa[tbl[i].id] = 25'(tbl[i].a);
            opb[tbl[i].id] = 18'(tbl[i].b);
            req_valid = 4'(1 << tbl[i].id);
            done = 0;
            for (int c = 0; c < 8 && !done; c++) begin
                cycle();
                if (got_rsp) begin
                    done = 1;
                    chk("tbl_p", got_p, tbl[i].p);
                    chk("tbl_id", longint'(got_id), longint'(tbl[i].id));
                end
            end
            if (!done) chk("tbl_timeout", 0, 1);
        end

        // Backpressure on a stream from requester 1
        acc0 = n_acc; rsp0 = n_rsp;
        for (int c = 0; c < 14; c++) begin
            if (!req_valid[1]) begin
                opa[1] = 25'($urandom);
                opb[1] = 18'($urandom);
                req_valid[1] = 1'b1;
            end
            rsp_ready = !(c >= 3 && c < 8);
            cycle();
        end
        req_valid = 4'b0000; rsp_ready = 1'b1;
        repeat (4) cycle();
        chk("bp_count", longint'(n_rsp - rsp0), longint'(n_acc - acc0));

        // Reset one cycle after an accept discards the in-flight product
        req_valid = 4'b0100;
        cycle();
        chk("rst_pre_grant", last_grant, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        req_valid = 4'b1001;
        cycle();
        chk("rst_first_grant", last_grant, 0);
        cycle();
        chk("rst_second_grant", last_grant, 3);
        repeat (3) cycle();

        // Pointer wrap: lone requester 3 then lone requester 0
        req_valid = 4'b1000;
        cycle();
        chk("wrap_grant3", last_grant, 3);
        req_valid = 4'b0001;
        cycle();
        chk("wrap_grant0", last_grant, 0);
        repeat (3) cycle();

        // Random traffic with random backpressure
        acc0 = n_acc; rsp0 = n_rsp;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    opa[i] = 25'($urandom);
                    opb[i] = 18'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom % 4) != 0;
            cycle();
        end
        req_valid = 4'b0000; rsp_ready = 1'b1;
        repeat (4) cycle();
        chk("rand_count", longint'(n_rsp - rsp0), longint'(n_acc - acc0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mul_arbiter.md
# dsp_mul_arbiter

Round-robin arbiter that shares one registered signed multiplier (A/B input registers, P output register, one DSP48E1 on Xilinx) between NREQ requesters. It grants at most one operand pair per cycle and tags it with the requester index. It returns the product on a single tagged response port. It generates the multiplier clock enables from response backpressure. It sits between several low-rate arithmetic clients and a single DSP slice so they need not each instantiate one.

## Interface
- NREQ, 4: number of requesters; legal range 2..16.
- AW, 25: signed A operand width.
- BW, 18: signed B operand width.
- IDW, $clog2(NREQ): requester tag width.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit set.
- req_a  input  NREQ*AW  packed signed A operands; requester i uses bits [i*AW +: AW].
- req_b  input  NREQ*BW  packed signed B operands; requester i uses bits [i*BW +: BW].
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  IDW  index of the requester that owns rsp_p.
- rsp_p  output  AW+BW  signed full-precision product A*B.
- busy  output  1  high while any operation is in flight (stage 1 or stage 2 valid).

## Operation
- Two pipeline stages:
  - S1 holds Ar, Br, id1 and v1 (input registers).
  - S2 holds P, id2 and v2 (output register). rsp_valid=v2, rsp_id=id2, rsp_p=P.
- stall = v2 & ~rsp_ready. Every pipeline register, including the tags and valids, is enabled by ~stall. This gives CEA=CEB=CEP=~stall, so the DSP absorbs Ar/Br/P.
- Arbitration is combinational and round-robin.
  - Search starts at index ptr and wraps at NREQ-1 -> 0. The first i with req_valid[i]=1 is grant g.
  - req_ready[g] = ~stall. All other bits of req_ready are 0.
- Accept (req_valid[g] & req_ready[g]):
  - Ar <= req_a slice g, Br <= req_b slice g, id1 <= g, v1 <= 1.
  - ptr <= (g+1) mod NREQ.
- No request and ~stall: v1 <= 0, ptr unchanged. Ar/Br may hold stale data.
- When ~stall: P <= Ar*Br (signed, AW+BW bits, exact, no truncation or saturation), id2 <= id1, v2 <= v1.
- Handshake rules:
  - req_valid must not depend on req_ready.
  - A requester holds its valid and operands stable until accepted.
  - The arbiter never drops or reorders: products emerge in grant order.
- busy = v1 | v2.

## Timing
- Reset, sampled at a clk edge with rst=1:
  - ptr=0, v1=0, v2=0.
  - rsp_valid=0, rsp_id=0, rsp_p=0.
  - busy=0, req_ready=0 in the reset cycle.
  - Ar/Br/P data are don't-care but read as 0 after reset.
- Reset mid-operation discards all in-flight products. No rsp_valid is produced for them.
- Latency: request accepted at edge N -> rsp_valid=1 with its product from edge N+1 (2 cycles from valid to response when unstalled).
- Throughput: one accept per cycle while rsp_ready=1.
- Stall: while rsp_valid=1 & rsp_ready=0:
  - req_ready=0 and all stages freeze.
  - rsp_p/rsp_id stay stable.
  - ptr does not move.
- The cycle rsp_ready rises, the held product completes and a new grant is accepted in the same cycle (no bubble).
- Simultaneous requests: exactly one grant per cycle. A requester with valid held continuously waits at most NREQ-1 accepts.
- Single requester: granted every cycle; ptr wraps past it harmlessly.

## Test plan
- Single op: req 2 with A=3, B=-5 at cycle 0 -> req_ready[2]=1 cycle 0; rsp_valid, rsp_id=2, rsp_p=-15 after edge 1; busy high 2 cycles.
- Fairness: all four requests held for 8 accepts after reset -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical; back-to-back rsp_valid.
- Extremes: A=-2^24, B=-2^17 -> rsp_p=2^41 (0x0200_0000_0000). A=2^24-1, B=-2^17 -> rsp_p=-(2^41-2^17).
- Backpressure: stream from req 1 with rsp_ready=0 for 5 cycles mid-stream -> rsp_p/rsp_id frozen; req_ready=0; no product lost or duplicated after release; order preserved.
- Reset mid-flight: assert rst one cycle after an accept -> rsp_valid stays 0, ptr=0; next request from 0 and 3 together -> 0 granted first.
- Pointer wrap: only req 3 then only req 0 -> both granted immediately; ptr goes 0->0 after the req-3 grant wraps ((3+1) mod 4).
